seven_segment_reader: RTL and testbench

- Receive end of the team's seven-segment display interface.
- Samples a multiplexed seven-segment bus (segment lines plus one-hot digit enables) and filters each digit for stability.
- Converts each stable segment pattern back to BCD and assembles a full multi-digit frame.
- Used for display loopback checking and for reading panels driven by the existing BCD-to-segment decoder.

---
 rtl/seven_segment_reader.sv | 141 ++++++++++++++
 tb/tb_seven_segment_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_reader.sv
// Receive side of the multiplexed seven-segment bus: filters each digit for
// stability, decodes the segment pattern back to BCD and assembles full frames.
module seven_segment_reader #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                seg,
    input  logic [NUM_DIGITS-1:0]     dig_en,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [NUM_DIGITS-1:0]     blank,
    output logic                      frame_valid,
    output logic                      err
);

    localparam int unsigned SAMPLE_W = 7 + NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SAMPLE_W-1:0]     r_held;
    logic [CNT_W-1:0]        r_cnt;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic                    r_frame_valid;
    logic                    r_err;

    logic [SAMPLE_W-1:0]     w_sample;
    logic                    w_onehot;
    logic                    w_same;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_capture;
    logic                    w_legal;
    logic                    w_is_blank;
    logic [3:0]              w_val;
    logic [4*NUM_DIGITS-1:0] w_bcd_next;
    logic [NUM_DIGITS-1:0]   w_blank_next;
    logic [NUM_DIGITS-1:0]   w_seen_next;
    logic                    w_frame_next;
    logic                    w_err_next;

    assign w_sample = {seg, dig_en};
    assign w_onehot = (dig_en != '0) && ((dig_en & (dig_en - NUM_DIGITS'(1))) == '0);
    assign w_same   = (w_sample == r_held);

    // Stability counter; a changed sample always restarts the run, so with a
    // single required sample the change itself is the capture condition.
    always_comb begin
        w_cnt_next = r_cnt;
        if (!w_onehot) begin
            w_cnt_next = '0;
        end else if (w_same) begin
            if (r_cnt != CNT_MAX) begin
                w_cnt_next = r_cnt + CNT_ONE;
            end
        end else begin
            w_cnt_next = CNT_ONE;
        end
    end

    assign w_capture = w_onehot && (w_cnt_next == CNT_MAX) && (!w_same || (r_cnt != CNT_MAX));

    // Segment pattern (abcdefg on seg[6:0]) back to BCD.
    always_comb begin
        w_legal    = 1'b1;
        w_is_blank = 1'b0;
        w_val      = 4'h0;
        case (seg)
            7'b1111110: w_val = 4'd0;
            7'b0110000: w_val = 4'd1;
            7'b1101101: w_val = 4'd2;
            7'b1111001: w_val = 4'd3;
            7'b0110011: w_val = 4'd4;
            7'b1011011: w_val = 4'd5;
            7'b1011111: w_val = 4'd6;
            7'b1110000: w_val = 4'd7;
            7'b1111111: w_val = 4'd8;
            7'b1111011: w_val = 4'd9;
            7'b0000000: begin
                w_legal    = 1'b0;
                w_is_blank = 1'b1;
                w_val      = 4'hF;
            end
            default:    w_legal = 1'b0;
        endcase
    end

    // Capture update and frame assembly.
    always_comb begin
        w_bcd_next   = r_bcd;
        w_blank_next = r_blank;
        w_seen_next  = r_seen;
        w_frame_next = 1'b0;
        w_err_next   = 1'b0;
        if (w_capture) begin
            if (w_legal || w_is_blank) begin
                for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                    if (dig_en[i]) begin
                        w_bcd_next[4*i +: 4] = w_val;
                        w_blank_next[i]      = w_is_blank;
                    end
                end
                w_seen_next = r_seen | dig_en;
            end else begin
                w_err_next = 1'b1;
            end
        end
        if (&w_seen_next) begin
            w_frame_next = 1'b1;
            w_seen_next  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held        <= '0;
            r_cnt         <= '0;
            r_seen        <= '0;
            r_bcd         <= '0;
            r_blank       <= '0;
            r_frame_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_held        <= w_sample;
            r_cnt         <= w_cnt_next;
            r_seen        <= w_seen_next;
            r_bcd         <= w_bcd_next;
            r_blank       <= w_blank_next;
            r_frame_valid <= w_frame_next;
            r_err         <= w_err_next;
        end
    end

    assign bcd_out     = r_bcd;
    assign blank       = r_blank;
    assign frame_valid = r_frame_valid;
    assign err         = r_err;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Randomized and directed bench for seven_segment_reader against a run-length
// based behavioural model of the capture and frame rules.
module tb_seven_segment_reader;

    localparam int ND     = 4;
    localparam int STABLE = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    seg;
    logic [ND-1:0] dig_en;
    logic [4*ND-1:0] bcd_out;
    logic [ND-1:0] blank;
    logic          frame_valid;
    logic          err;

    seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst(rst), .seg(seg), .dig_en(dig_en),
        .bcd_out(bcd_out), .blank(blank), .frame_valid(frame_valid), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int fv_count = 0;
    int err_count = 0;

    // Model state: unbounded run length of identical samples.
    int            run;
    logic [10:0]   prev;
    logic [3:0]    m_bcd [ND];
    logic [ND-1:0] m_blank;
    logic [ND-1:0] m_seen;
    logic          m_fv;
    logic          m_err;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // Returns 0..9 for a digit, 15 for blank, -1 for an illegal pattern.
    function automatic int decode(input logic [6:0] s);
        if (s == 7'b0000000) return 15;
        for (int d = 0; d < 10; d++) if (seg_of(d) == s) return d;
        return -1;
    endfunction

    function automatic void model_reset();
        run = 0;
        prev = '0;
        for (int i = 0; i < ND; i++) m_bcd[i] = 4'h0;
        m_blank = '0;
        m_seen = '0;
        m_fv = 1'b0;
        m_err = 1'b0;
    endfunction

    function automatic void model_step(input logic [6:0] s, input logic [ND-1:0] e);
        logic [10:0] cur;
        int d;
        cur = {s, e};
        m_fv = 1'b0;
        m_err = 1'b0;
        if ($countones(e) != 1) run = 0;
        else if (cur == prev) run = run + 1;
        else run = 1;
        prev = cur;
        if ($countones(e) == 1 && run == STABLE) begin
            d = decode(s);
            if (d < 0) begin
                m_err = 1'b1;
            end else begin
                for (int i = 0; i < ND; i++) begin
                    if (e[i]) begin
                        m_bcd[i] = 4'(d);
                        m_blank[i] = (d == 15);
                        m_seen[i] = 1'b1;
                    end
                end
                if (m_seen == '1) begin
                    m_fv = 1'b1;
                    m_seen = '0;
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [4*ND-1:0] eb;
        for (int i = 0; i < ND; i++) eb[4*i +: 4] = m_bcd[i];
        check("bcd_out", 32'(bcd_out), 32'(eb));
        check("blank", 32'(blank), 32'(m_blank));
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("err", 32'(err), 32'(m_err));
    endtask

    // One clock: drive at negedge, model on posedge, compare at next negedge.
    task automatic cycle(input logic [6:0] s, input logic [ND-1:0] e);
        seg = s;
        dig_en = e;
        @(posedge clk);
        if (!rst) model_step(s, e);
        @(negedge clk);
        compare_all();
        if (frame_valid === 1'b1) fv_count++;
        if (err === 1'b1) err_count++;
    endtask

    task automatic hold(input logic [6:0] s, input logic [ND-1:0] e, input int n);
        for (int k = 0; k < n; k++) cycle(s, e);
    endtask

    // Async reset asserted between edges; outputs must clear without a clock.
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check("rst_bcd", 32'(bcd_out), 32'h0);
        check("rst_blank", 32'(blank), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] s;
        logic [ND-1:0] e;
        int r;
        rst = 1'b1;
        seg = '0;
        dig_en = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;

        // Reset mid-frame, then digits 2-3 alone must not complete a frame.
        hold(seg_of(1), 4'b0001, 3);
        hold(seg_of(2), 4'b0010, 3);
        pulse_reset();
        fv_count = 0;
        hold(seg_of(3), 4'b0100, 3);
        hold(seg_of(4), 4'b1000, 3);
        check("partial_frame_fv", 32'(fv_count), 32'd0);

        // Single digit held 10 cycles.
        pulse_reset();
        fv_count = 0;
        cycle(seg_of(1), 4'b0001);
        cycle(seg_of(1), 4'b0001);
        check("hold_before", 32'(bcd_out[3:0]), 32'h0);
        cycle(seg_of(1), 4'b0001);
        check("hold_edge3", 32'(bcd_out[3:0]), 32'h1);
        hold(seg_of(1), 4'b0001, 7);
        check("hold_no_fv", 32'(fv_count), 32'd0);

        // Short run of 2 then a stable 3.
        hold(seg_of(2), 4'b0001, 2);
        check("short_run", 32'(bcd_out[3:0]), 32'h1);
        hold(seg_of(3), 4'b0001, 3);
        check("second_run", 32'(bcd_out[3:0]), 32'h3);

        // Full frame 1,2,3,4.
        pulse_reset();
        fv_count = 0;
        for (int d = 0; d < ND; d++) hold(seg_of(d + 1), ND'(1 << d), 3);
        check("frame_fv_pulse", 32'(frame_valid), 32'h1);
        check("frame_bcd", 32'(bcd_out), 32'h4321);
        cycle(seg_of(4), 4'b1000);
        check("frame_fv_count", 32'(fv_count), 32'd1);

        // Illegal stable pattern.
        err_count = 0;
        fv_count = 0;
        hold(7'b1110111, 4'b0100, 4);
        check("illegal_err_count", 32'(err_count), 32'd1);
        check("illegal_nibble2", 32'(bcd_out[11:8]), 32'h3);
        check("illegal_no_fv", 32'(fv_count), 32'd0);

        // Blank then legal on digit 1.
        pulse_reset();
        hold(7'b0000000, 4'b0010, 3);
        check("blank_mask", 32'(blank), 32'b0010);
        check("blank_nibble", 32'(bcd_out[7:4]), 32'hF);
        hold(seg_of(1), 4'b0010, 3);
        check("unblank_mask", 32'(blank), 32'b0000);
        check("unblank_nibble", 32'(bcd_out[7:4]), 32'h1);

        // Multi-hot enables never capture.
        err_count = 0;
        hold(seg_of(7), 4'b0011, 5);
        check("multihot_bcd", 32'(bcd_out), 32'h0010);
        check("multihot_err", 32'(err_count), 32'd0);

        // Randomized bursts.
        for (int b = 0; b < 600; b++) begin
            r = int'($urandom_range(0, 99));
            if (r < 85) e = ND'(1 << $urandom_range(0, ND - 1));
            else e = ND'($urandom);
            r = int'($urandom_range(0, 99));
            if (r < 70) s = seg_of(int'($urandom_range(0, 9)));
            else if (r < 80) s = 7'b0000000;
            else s = 7'($urandom);
            hold(s, e, int'($urandom_range(1, 5)));
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
